// File: rtl/riscv_dmem_pkg.sv
// Shared types for the data-memory responder: op classes, FSM states, response slots.
// Optional range checking is controlled by the RISCV_DMEM_RANGE_CHECK_EN macro in the top.
package riscv_dmem_pkg;

   typedef enum logic [1:0] {
      OP_READ,
      OP_WRITE,
      OP_MAINT,
      OP_BAD
   } op_class_e;

   typedef enum logic {
      S_READY,
      S_MAINT
   } state_e;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [10:0] tag;
      logic        is_read;
   } resp_slot_t;

   // Maintenance wins over everything; rd together with strobes is malformed.
   function automatic op_class_e classify(input logic rd, input logic [3:0] wr, input logic maint);
      if (maint)
         return OP_MAINT;
      else if (rd && (|wr))
         return OP_BAD;
      else if (|wr)
         return OP_WRITE;
      else
         return OP_READ;
   endfunction

endpackage

// File: rtl/riscv_dmem_ram.sv
// Single-port data RAM, DEPTH_WORDS x 32, per-byte write enables, registered read.
module riscv_dmem_ram #(
   parameter int DEPTH_WORDS = 4096,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             re,
   input  logic [3:0]       we,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b])
            mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (re)
         rdata <= mem[idx];
   end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Memory-side responder for the LSU/MMU load-store bus with fixed-latency in-order acks.
// Define RISCV_DMEM_RANGE_CHECK_EN to error out reads/writes outside the RAM window.
module riscv_dmem_responder
   import riscv_dmem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
   parameter int          DEPTH_WORDS  = 4096,
   parameter int          LATENCY      = 2,
   parameter int          FLUSH_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] mem_ls_addr,
   input  logic [31:0] mem_ls_wdata,
   input  logic        mem_ls_rd,
   input  logic [3:0]  mem_ls_wr,
   input  logic        mem_ls_cacheable,
   input  logic [10:0] mem_ls_req_tag,
   input  logic        mem_ls_inval,
   input  logic        mem_ls_wb,
   input  logic        mem_ls_flush,
   output logic        mem_ls_accept,
   output logic        mem_ls_ack,
   output logic        mem_ls_error,
   output logic [31:0] mem_ls_rdata,
   output logic [10:0] mem_ls_resp_tag
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_e     state, state_nx;
   logic [7:0] cnt, cnt_nx;

   logic             maint, present, take, range_ok;
   op_class_e        op;
   logic             ram_re;
   logic [3:0]       ram_we;
   logic [IDX_W-1:0] idx;
   logic [31:0]      ram_rdata, out_data;
   resp_slot_t       slot_in, head;
   resp_slot_t       slot_q [1:LATENCY];

   // Attribute and sub-word address bits never influence the response.
   logic unused_bits;
   assign unused_bits = ^{mem_ls_cacheable, mem_ls_addr, BASE_ADDR};

   assign maint   = mem_ls_inval | mem_ls_wb | mem_ls_flush;
   assign present = mem_ls_rd | (|mem_ls_wr) | maint;
   assign mem_ls_accept = rst_n && (state == S_READY);
   assign take    = mem_ls_accept && present;
   assign op      = classify(mem_ls_rd, mem_ls_wr, maint);
   assign idx     = mem_ls_addr[IDX_W+1:2];

`ifdef RISCV_DMEM_RANGE_CHECK_EN
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
   logic [32:0] offset;
   // Addresses below the base wrap to a huge 33-bit offset and fail the compare.
   assign offset   = {1'b0, mem_ls_addr} - {1'b0, BASE_ADDR};
   assign range_ok = (offset < SPAN);
`else
   assign range_ok = 1'b1;
`endif

   always_comb begin
      ram_re  = take && (op == OP_READ) && range_ok;
      ram_we  = (take && (op == OP_WRITE) && range_ok) ? mem_ls_wr : 4'b0000;
      slot_in = '0;
      slot_in.valid   = take;
      slot_in.err     = take && ((op == OP_BAD) ||
                                 (((op == OP_READ) || (op == OP_WRITE)) && !range_ok));
      slot_in.tag     = mem_ls_req_tag;
      slot_in.is_read = ram_re;
   end

   riscv_dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clk   (clk),
      .re    (ram_re),
      .we    (ram_we),
      .idx   (idx),
      .wdata (mem_ls_wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         S_READY: begin
            if (take && (op == OP_MAINT)) begin
               state_nx = S_MAINT;
               cnt_nx   = 8'(FLUSH_CYCLES);
            end
         end
         S_MAINT: begin
            if (cnt == 8'd1) begin
               state_nx = S_READY;
               cnt_nx   = 8'd0;
            end else begin
               cnt_nx = cnt - 8'd1;
            end
         end
         default: begin
            state_nx = S_READY;
            cnt_nx   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_READY;
         cnt   <= 8'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Stage 1 lines up with the registered RAM read; later stages carry both forward.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 1; k <= LATENCY; k++)
            slot_q[k] <= '0;
      end else begin
         slot_q[1] <= slot_in;
         for (int k = 2; k <= LATENCY; k++)
            slot_q[k] <= slot_q[k-1];
      end
   end

   generate
      if (LATENCY == 1) begin : g_lat1
         assign out_data = ram_rdata;
      end else begin : g_latn
         logic [31:0] data_q [2:LATENCY];
         always_ff @(posedge clk) begin
            data_q[2] <= ram_rdata;
            for (int k = 3; k <= LATENCY; k++)
               data_q[k] <= data_q[k-1];
         end
         assign out_data = data_q[LATENCY];
      end
   endgenerate

   assign head            = slot_q[LATENCY];
   assign mem_ls_ack      = rst_n && head.valid;
   assign mem_ls_error    = mem_ls_ack && head.err;
   assign mem_ls_resp_tag = mem_ls_ack ? head.tag : 11'd0;
   assign mem_ls_rdata    = (mem_ls_ack && head.is_read) ? out_data : 32'd0;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder: scoreboard of expected acks, timing and reset checks.
// Follows RISCV_DMEM_RANGE_CHECK_EN for the out-of-window read.
module tb_riscv_dmem_responder;

   localparam int          LATENCY      = 2;
   localparam int          FLUSH_CYCLES = 8;
   localparam int          DEPTH_WORDS  = 4096;
   localparam logic [31:0] BASE_ADDR    = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] mem_ls_addr = '0;
   logic [31:0] mem_ls_wdata = '0;
   logic        mem_ls_rd = 1'b0;
   logic [3:0]  mem_ls_wr = '0;
   logic        mem_ls_cacheable = 1'b0;
   logic [10:0] mem_ls_req_tag = '0;
   logic        mem_ls_inval = 1'b0;
   logic        mem_ls_wb = 1'b0;
   logic        mem_ls_flush = 1'b0;
   logic        mem_ls_accept;
   logic        mem_ls_ack;
   logic        mem_ls_error;
   logic [31:0] mem_ls_rdata;
   logic [10:0] mem_ls_resp_tag;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [10:0] exp_tag_q[$];
   logic [31:0] exp_q[$];
   logic        exp_err_q[$];
   int          exp_cyc_q[$];

   riscv_dmem_responder #(
      .BASE_ADDR    (BASE_ADDR),
      .DEPTH_WORDS  (DEPTH_WORDS),
      .LATENCY      (LATENCY),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .mem_ls_addr      (mem_ls_addr),
      .mem_ls_wdata     (mem_ls_wdata),
      .mem_ls_rd        (mem_ls_rd),
      .mem_ls_wr        (mem_ls_wr),
      .mem_ls_cacheable (mem_ls_cacheable),
      .mem_ls_req_tag   (mem_ls_req_tag),
      .mem_ls_inval     (mem_ls_inval),
      .mem_ls_wb        (mem_ls_wb),
      .mem_ls_flush     (mem_ls_flush),
      .mem_ls_accept    (mem_ls_accept),
      .mem_ls_ack       (mem_ls_ack),
      .mem_ls_error     (mem_ls_error),
      .mem_ls_rdata     (mem_ls_rdata),
      .mem_ls_resp_tag  (mem_ls_resp_tag)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic idle_inputs();
      mem_ls_rd      = 1'b0;
      mem_ls_wr      = 4'b0000;
      mem_ls_addr    = '0;
      mem_ls_wdata   = '0;
      mem_ls_req_tag = '0;
      mem_ls_inval   = 1'b0;
      mem_ls_wb      = 1'b0;
      mem_ls_flush   = 1'b0;
   endtask

   // Called at posedge+1; holds the request until accepted, returns at the next posedge+1.
   task automatic issue(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [10:0] tag, input logic [2:0] mnt,
                        input logic [31:0] exp_data, input logic exp_err, input bit track,
                        output int acc_cyc);
      mem_ls_rd        = rd;
      mem_ls_wr        = wr;
      mem_ls_addr      = addr;
      mem_ls_wdata     = wdata;
      mem_ls_req_tag   = tag;
      mem_ls_cacheable = $urandom_range(0, 1) == 1;
      {mem_ls_inval, mem_ls_wb, mem_ls_flush} = mnt;
      acc_cyc = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (mem_ls_accept) begin
            acc_cyc = cyc;
            break;
         end
      end
      if (acc_cyc < 0) begin
         check("accept_timeout", 32'd0, 32'd1);
      end else if (track) begin
         exp_tag_q.push_back(tag);
         exp_q.push_back(exp_data);
         exp_err_q.push_back(exp_err);
         exp_cyc_q.push_back(acc_cyc + LATENCY);
      end
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // scoreboard / monitor
   always @(negedge clk) begin
      if (mem_ls_ack) begin
         if (exp_tag_q.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
         end else begin
            check("ack_tag",   32'(mem_ls_resp_tag), 32'(exp_tag_q.pop_front()));
            check("ack_rdata", mem_ls_rdata, exp_q.pop_front());
            check("ack_error", 32'(mem_ls_error), 32'(exp_err_q.pop_front()));
            check("ack_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
         end
      end else begin
         check("idle_outputs", mem_ls_rdata | 32'(mem_ls_resp_tag) | 32'(mem_ls_error), 32'd0);
      end
   end

   int a0, a1, prev;

   initial begin
      idle_inputs();
      // reset values while rst_n is low
      repeat (3) @(negedge clk);
      check("rst_accept", 32'(mem_ls_accept), 32'd0);
      check("rst_ack",    32'(mem_ls_ack),    32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("accept_after_rst", 32'(mem_ls_accept), 32'd1);
      @(posedge clk);
      #1;

      // full-word write then read-after-write
      issue(1'b0, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, 11'h05A, 3'b000, 32'h0, 1'b0, 1'b1, a0);
      issue(1'b1, 4'h0, 32'h8000_0010, 32'h0,         11'h05B, 3'b000, 32'hDEAD_BEEF, 1'b0, 1'b1, a1);
      check("raw_back_to_back", 32'(a1 - a0), 32'd1);

      // byte-strobe merge
      issue(1'b0, 4'hF,    32'h8000_0020, 32'h1122_3344, 11'h010, 3'b000, 32'h0, 1'b0, 1'b1, a0);
      issue(1'b0, 4'b0010, 32'h8000_0020, 32'h0000_AB00, 11'h011, 3'b000, 32'h0, 1'b0, 1'b1, a0);
      issue(1'b1, 4'h0,    32'h8000_0020, 32'h0,         11'h012, 3'b000, 32'h1122_AB44, 1'b0, 1'b1, a0);

      // malformed request leaves memory untouched; reserved walk tag echoes as-is
      issue(1'b0, 4'hF, 32'h8000_0030, 32'hCAFE_F00D, 11'h020, 3'b000, 32'h0, 1'b0, 1'b1, a0);
      issue(1'b1, 4'hF, 32'h8000_0030, 32'h0BAD_0BAD, 11'h021, 3'b000, 32'h0, 1'b1, 1'b1, a0);
      issue(1'b1, 4'h0, 32'h8000_0030, 32'h0,         11'h380, 3'b000, 32'hCAFE_F00D, 1'b0, 1'b1, a0);

      // preload then 16 back-to-back reads with tags 0..15
      for (int i = 0; i < 16; i++)
         issue(1'b0, 4'hF, 32'h8000_0100 + 32'(4*i), 32'h1000_0000 + 32'(i) * 32'h0001_0111,
               11'(11'h100 + i), 3'b000, 32'h0, 1'b0, 1'b1, a0);
      prev = 0;
      for (int i = 0; i < 16; i++) begin
         issue(1'b1, 4'h0, 32'h8000_0100 + 32'(4*i), 32'h0, 11'(i), 3'b000,
               32'h1000_0000 + 32'(i) * 32'h0001_0111, 1'b0, 1'b1, a0);
         if (i > 0)
            check("stream_accept_gap", 32'(a0 - prev), 32'd1);
         prev = a0;
      end
      wait_cycles(4);

      // flush stalls the port; a read waiting behind it is taken at C+FLUSH_CYCLES+1
      issue(1'b0, 4'h0, 32'h0, 32'h0, 11'h0F0, 3'b001, 32'h0, 1'b0, 1'b1, a0);
      issue(1'b1, 4'h0, 32'h8000_0010, 32'h0, 11'h0F1, 3'b000, 32'hDEAD_BEEF, 1'b0, 1'b1, a1);
      check("flush_stall", 32'(a1 - a0), 32'(FLUSH_CYCLES + 1));

      // writeback behind an in-flight read
      issue(1'b1, 4'h0, 32'h8000_0020, 32'h0, 11'h0F2, 3'b000, 32'h1122_AB44, 1'b0, 1'b1, a0);
      issue(1'b0, 4'h0, 32'h0, 32'h0, 11'h0F3, 3'b010, 32'h0, 1'b0, 1'b1, a0);
      issue(1'b1, 4'h0, 32'h8000_0020, 32'h0, 11'h0F4, 3'b000, 32'h1122_AB44, 1'b0, 1'b1, a1);
      check("wb_stall", 32'(a1 - a0), 32'(FLUSH_CYCLES + 1));

      // top word and the aliasing / out-of-window read below the base
      issue(1'b0, 4'hF, 32'h8000_3FFC, 32'h5A5A_1234, 11'h040, 3'b000, 32'h0, 1'b0, 1'b1, a0);
`ifdef RISCV_DMEM_RANGE_CHECK_EN
      issue(1'b1, 4'h0, 32'h7FFF_FFFC, 32'h0, 11'h041, 3'b000, 32'h0, 1'b1, 1'b1, a0);
`else
      issue(1'b1, 4'h0, 32'h7FFF_FFFC, 32'h0, 11'h041, 3'b000, 32'h5A5A_1234, 1'b0, 1'b1, a0);
`endif
      wait_cycles(4);

      // reset one cycle after accepting a read: that response must never appear
      issue(1'b1, 4'h0, 32'h8000_0010, 32'h0, 11'h077, 3'b000, 32'h0, 1'b0, 1'b0, a0);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mid_rst_accept", 32'(mem_ls_accept), 32'd0);
         check("mid_rst_ack",    32'(mem_ls_ack),    32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("accept_after_mid_rst", 32'(mem_ls_accept), 32'd1);
      @(posedge clk);
      #1;
      wait_cycles(6);

      // memory survives reset
      issue(1'b1, 4'h0, 32'h8000_0030, 32'h0, 11'h078, 3'b000, 32'hCAFE_F00D, 1'b0, 1'b1, a0);

      for (int i = 0; i < 20 && exp_tag_q.size() != 0; i++)
         @(posedge clk);
      @(negedge clk);
      check("drain_pending", 32'(exp_tag_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
